// File: rtl/reg_bus_ctrl_if.sv
// Bus/control bundle between the register-datapath sequencer and its datapath.
// The master side is the sequencer; the slave side supplies run/din and consumes enables.
interface reg_bus_ctrl_if #(
  parameter int NREG   = 8,
  parameter int DATA_W = 16
);
  logic              run;
  logic [DATA_W-1:0] din;
  logic [NREG-1:0]   rin;
  logic [NREG-1:0]   rout;
  logic              ain;
  logic              gin;
  logic              gout;
  logic              dinout;
  logic              addsub;
  logic              done;
  logic              busy;

  modport master (
    input  run, din,
    output rin, rout, ain, gin, gout, dinout, addsub, done, busy
  );

  modport slave (
    output run, din,
    input  rin, rout, ain, gin, gout, dinout, addsub, done, busy
  );
endinterface

// File: rtl/reg_bus_ctrl.sv
// Step sequencer for the shared-bus register datapath: fetches a 9-bit instruction
// and decodes step counter + IR into one-hot load enables and bus-driver selects.
module reg_bus_ctrl #(
  parameter int NREG   = 8,
  parameter int IRW    = 9,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  reg_bus_ctrl_if.master    bus
);

  typedef enum logic [1:0] {T0 = 2'd0, T1 = 2'd1, T2 = 2'd2, T3 = 2'd3} step_t;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  step_t            step;
  step_t            step_next;
  logic [IRW-1:0]   ir;
  logic [2:0]       op;
  logic [2:0]       x;
  logic [2:0]       y;

  logic [NREG-1:0]  rin;
  logic [NREG-1:0]  rout;
  logic             ain;
  logic             gin;
  logic             gout;
  logic             dinout;
  logic             addsub;
  logic             done;

  // Low din bits carry no instruction information.
  logic             unused_din;
  assign unused_din = ^bus.din[DATA_W-IRW-1:0];

  assign op = ir[IRW-1 -: 3];
  assign x  = ir[5:3];
  assign y  = ir[2:0];

  function automatic logic [NREG-1:0] onehot(input logic [2:0] idx);
    logic [NREG-1:0] v;
    v = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      step <= T0;
      ir   <= '0;
    end else begin
      step <= step_next;
      if (step == T0 && bus.run)
        ir <= bus.din[DATA_W-1 -: IRW];
    end
  end

  // Outputs are a pure decode of step/IR, so reset clears them without a clock.
  always_comb begin
    step_next = step;
    rin       = '0;
    rout      = '0;
    ain       = 1'b0;
    gin       = 1'b0;
    gout      = 1'b0;
    dinout    = 1'b0;
    addsub    = 1'b0;
    done      = 1'b0;
    unique case (step)
      T0: begin
        if (bus.run)
          step_next = T1;
      end
      T1: begin
        case (op)
          OP_MV: begin
            rout      = onehot(y);
            rin       = onehot(x);
            done      = 1'b1;
            step_next = T0;
          end
          OP_MVI: begin
            dinout    = 1'b1;
            rin       = onehot(x);
            done      = 1'b1;
            step_next = T0;
          end
          OP_ADD, OP_SUB: begin
            rout      = onehot(x);
            ain       = 1'b1;
            step_next = T2;
          end
          default: begin
            done      = 1'b1;
            step_next = T0;
          end
        endcase
      end
      T2: begin
        rout      = onehot(y);
        gin       = 1'b1;
        addsub    = (op == OP_SUB);
        step_next = T3;
      end
      T3: begin
        gout      = 1'b1;
        rin       = onehot(x);
        done      = 1'b1;
        step_next = T0;
      end
      default: step_next = T0;
    endcase
  end

  assign bus.rin    = rin;
  assign bus.rout   = rout;
  assign bus.ain    = ain;
  assign bus.gin    = gin;
  assign bus.gout   = gout;
  assign bus.dinout = dinout;
  assign bus.addsub = addsub;
  assign bus.done   = done;
  assign bus.busy   = (step != T0);

endmodule

// File: tb/tb_reg_bus_ctrl.sv
// Directed bench for reg_bus_ctrl with a small behavioural register datapath
// attached, so register contents after each instruction can be checked too.
module tb_reg_bus_ctrl;

  logic clock;
  logic reset;

  reg_bus_ctrl_if #(.NREG(8), .DATA_W(16)) bus ();

  reg_bus_ctrl #(.NREG(8), .IRW(9), .DATA_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Datapath model: eight registers, A, G and an adder on a shared bus.
  logic [15:0] r [8];
  logic [15:0] a_reg;
  logic [15:0] g_reg;
  logic [15:0] bus_val;

  always_comb begin
    bus_val = '0;
    if (bus.dinout)
      bus_val = bus.din;
    else if (bus.gout)
      bus_val = g_reg;
    else
      for (int i = 0; i < 8; i++)
        if (bus.rout[i]) bus_val = r[i];
  end

  always @(posedge clock) begin
    for (int i = 0; i < 8; i++)
      if (bus.rin[i]) r[i] <= bus_val;
    if (bus.ain) a_reg <= bus_val;
    if (bus.gin) g_reg <= bus.addsub ? (a_reg - bus_val) : (a_reg + bus_val);
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Packs {rin, rout, ain, gin, gout, dinout, addsub, done, busy}.
  function automatic logic [31:0] ctl_obs();
    return {9'd0, bus.rin, bus.rout, bus.ain, bus.gin, bus.gout,
            bus.dinout, bus.addsub, bus.done, bus.busy};
  endfunction

  function automatic logic [31:0] ctl(input logic [7:0] rin, input logic [7:0] rout,
                                      input logic ain, input logic gin, input logic gout,
                                      input logic dinout, input logic addsub,
                                      input logic done, input logic busy);
    return {9'd0, rin, rout, ain, gin, gout, dinout, addsub, done, busy};
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [15:0] instr(input logic [2:0] op, input logic [2:0] x,
                                        input logic [2:0] y);
    return {op, x, y, 7'b0};
  endfunction

  task automatic do_mvi(input logic [2:0] x, input logic [15:0] val);
    bus.run = 1'b1;
    bus.din = instr(3'b001, x, 3'b000);
    tick();
    bus.run = 1'b0;
    bus.din = val;
    tick();
  endtask

  int excl;

  initial begin
    reset   = 1'b1;
    bus.run = 1'b0;
    bus.din = '0;
    #12;
    check("reset_outputs", ctl_obs(), 32'd0);
    tick();
    reset = 1'b0;
    check("post_reset_idle", ctl_obs(), 32'd0);

    // mvi R2 <- 0x1234
    bus.run = 1'b1;
    bus.din = instr(3'b001, 3'b010, 3'b000);
    tick();
    bus.run = 1'b0;
    bus.din = 16'h1234;
    check("mvi_t1", ctl_obs(), ctl(8'h04, 8'h00, 0, 0, 0, 1, 0, 1, 1));
    tick();
    check("mvi_back_t0", ctl_obs(), 32'd0);

    // mv R3 <- R2
    bus.run = 1'b1;
    bus.din = instr(3'b000, 3'b011, 3'b010);
    tick();
    bus.run = 1'b0;
    check("mv_t1", ctl_obs(), ctl(8'h08, 8'h04, 0, 0, 0, 0, 0, 1, 1));
    tick();
    check("mv_r3", {16'd0, r[3]}, 32'h1234);

    // add R1 <- R1 + R2 with R1=5, R2=7
    do_mvi(3'd1, 16'd5);
    do_mvi(3'd2, 16'd7);
    bus.run = 1'b1;
    bus.din = instr(3'b010, 3'b001, 3'b010);
    tick();
    bus.run = 1'b0;
    check("add_t1", ctl_obs(), ctl(8'h00, 8'h02, 1, 0, 0, 0, 0, 0, 1));
    tick();
    check("add_t2", ctl_obs(), ctl(8'h00, 8'h04, 0, 1, 0, 0, 0, 0, 1));
    tick();
    check("add_t3", ctl_obs(), ctl(8'h02, 8'h00, 0, 0, 1, 0, 0, 1, 1));
    tick();
    check("add_busy_low", {31'd0, bus.busy}, 32'd0);
    check("add_r1", {16'd0, r[1]}, 32'd12);

    // sub R0 <- R0 - R1 with R0=3, R1=5 wraps to 0xFFFE
    do_mvi(3'd0, 16'd3);
    do_mvi(3'd1, 16'd5);
    bus.run = 1'b1;
    bus.din = instr(3'b011, 3'b000, 3'b001);
    tick();
    bus.run = 1'b0;
    check("sub_t1", ctl_obs(), ctl(8'h00, 8'h01, 1, 0, 0, 0, 0, 0, 1));
    tick();
    check("sub_t2", ctl_obs(), ctl(8'h00, 8'h02, 0, 1, 0, 0, 1, 0, 1));
    tick();
    check("sub_t3", ctl_obs(), ctl(8'h01, 8'h00, 0, 0, 1, 0, 0, 1, 1));
    tick();
    check("sub_r0", {16'd0, r[0]}, 32'hFFFE);

    // Idle with run low, din carrying a live-looking instruction
    bus.din = instr(3'b010, 3'b001, 3'b010);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("idle", ctl_obs(), 32'd0);
    end

    // No-op 110_111_111
    bus.run = 1'b1;
    bus.din = instr(3'b110, 3'b111, 3'b111);
    tick();
    bus.run = 1'b0;
    check("noop_t1", ctl_obs(), ctl(8'h00, 8'h00, 0, 0, 0, 0, 0, 1, 1));
    tick();
    check("noop_back_t0", ctl_obs(), 32'd0);

    // Reset in T2 of add R1 <- R1 + R2 (R1=5, R2=7)
    bus.run = 1'b1;
    bus.din = instr(3'b010, 3'b001, 3'b010);
    tick();
    bus.run = 1'b0;
    tick();
    check("rst_pre_t2", ctl_obs(), ctl(8'h00, 8'h04, 0, 1, 0, 0, 0, 0, 1));
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_clear", ctl_obs(), 32'd0);
    tick();
    check("rst_held", ctl_obs(), 32'd0);
    reset = 1'b0;
    tick();
    check("rst_no_t3", ctl_obs(), 32'd0);
    check("rst_r1_kept", {16'd0, r[1]}, 32'd5);
    bus.run = 1'b1;
    bus.din = instr(3'b000, 3'b100, 3'b001);
    tick();
    bus.run = 1'b0;
    check("rst_refetch_mv", ctl_obs(), ctl(8'h10, 8'h02, 0, 0, 0, 0, 0, 1, 1));
    tick();
    check("rst_refetch_r4", {16'd0, r[4]}, 32'd5);

    // Back-to-back with run held: add R1+=R2, mv R6<-R1, mvi R7<-0xBEEF
    bus.run = 1'b1;
    bus.din = instr(3'b010, 3'b001, 3'b010);
    for (int c = 1; c <= 8; c++) begin
      tick();
      excl = (bus.rout != 8'h00 ? 1 : 0) + (bus.gout ? 1 : 0) + (bus.dinout ? 1 : 0);
      check("b2b_bus_excl", {31'd0, excl <= 1}, 32'd1);
      check("b2b_onehot", {30'd0, $onehot0(bus.rin), $onehot0(bus.rout)}, 32'd3);
      check($sformatf("b2b_done_c%0d", c), {31'd0, bus.done},
            {31'd0, (c == 3 || c == 5 || c == 7)});
      if (c == 4) bus.din = instr(3'b000, 3'b110, 3'b001);
      if (c == 6) bus.din = instr(3'b001, 3'b111, 3'b000);
      if (c == 7) bus.din = 16'hBEEF;
      if (c == 8) bus.run = 1'b0;
    end
    tick();
    check("b2b_idle", ctl_obs(), 32'd0);
    check("b2b_r1", {16'd0, r[1]}, 32'd12);
    check("b2b_r6", {16'd0, r[6]}, 32'd12);
    check("b2b_r7", {16'd0, r[7]}, 32'hBEEF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
